// File: rtl/fr_ctr_pkg.sv
// Shared types and helpers for the free-running counter bank.
package fr_ctr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_t;

  localparam int unsigned WRAP = 0;
  localparam int unsigned SAT  = 1;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << w) < 64'(n)) w++;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/fr_ctr_chan.sv
// Single event counter with sticky overflow flag and selectable wrap/saturate.
module fr_ctr_chan
  import fr_ctr_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SATURATE = WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] val,
  output logic             ovf
);

  always_ff @(posedge clk) begin
    if (rst) begin
      val <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      val <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      if (val == '1) begin
        ovf <= 1'b1;
        if (SATURATE == WRAP) val <= '0;
      end else begin
        val <= val + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/fr_ctr_bank.sv
// Bank of event counters with an atomic snapshot streamed out one word per handshake.
module fr_ctr_bank
  import fr_ctr_pkg::*;
#(
  parameter  int unsigned WIDTH    = 32,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned SATURATE = WRAP,
  localparam int unsigned CW       = clog2_min1(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] clr,
  output logic [CHANNELS-1:0] ovf,
  input  logic                snap,
  output logic                busy,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [CW-1:0]       rd_chan,
  output logic [WIDTH-1:0]    rd_data
);

  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

  logic [WIDTH-1:0] cnt    [CHANNELS];
  logic [WIDTH-1:0] shadow [CHANNELS];

  rd_state_t     state, state_nx;
  logic [CW-1:0] chan, chan_nx;
  logic          load;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    fr_ctr_chan #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_chan (
      .clk (clk),
      .rst (rst),
      .en  (en[g]),
      .clr (clr[g]),
      .val (cnt[g]),
      .ovf (ovf[g])
    );
  end

  // Shadow captures the pre-edge counts, so a coincident clr/en is not visible in the snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      chan  <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) shadow[i] <= '0;
    end else begin
      state <= state_nx;
      chan  <= chan_nx;
      if (load) begin
        for (int unsigned i = 0; i < CHANNELS; i++) shadow[i] <= cnt[i];
      end
    end
  end

  always_comb begin
    state_nx = state;
    chan_nx  = chan;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (snap) begin
          load     = 1'b1;
          chan_nx  = '0;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (rd_ready) begin
          if (chan == LAST) begin
            chan_nx  = '0;
            state_nx = IDLE;
          end else begin
            chan_nx = chan + CW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy     = (state == SEND);
  assign rd_valid = (state == SEND);
  assign rd_chan  = chan;
  assign rd_data  = shadow[chan];

endmodule

// File: tb/tb_fr_ctr_bank.sv
// Checks a wrap-mode and a saturate-mode bank driven in lockstep against a queue-based model.
module tb_fr_ctr_bank;

  localparam int unsigned W   = 8;
  localparam int unsigned N   = 4;
  localparam int unsigned MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] en = '0, clr = '0;
  logic         snap = 1'b0, rd_ready = 1'b0;

  logic [N-1:0] ovf0, ovf1;
  logic         busy0, busy1, valid0, valid1;
  logic [1:0]   chan0, chan1;
  logic [W-1:0] data0, data1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fr_ctr_bank #(.WIDTH(W), .CHANNELS(N), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ovf(ovf0), .snap(snap), .busy(busy0),
    .rd_valid(valid0), .rd_ready(rd_ready), .rd_chan(chan0), .rd_data(data0)
  );

  fr_ctr_bank #(.WIDTH(W), .CHANNELS(N), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ovf(ovf1), .snap(snap), .busy(busy1),
    .rd_valid(valid1), .rd_ready(rd_ready), .rd_chan(chan1), .rd_data(data1)
  );

  // Reference model: counts per mode, plus the pending readout as a queue of words.
  typedef struct {
    int unsigned chan;
    int unsigned d0;
    int unsigned d1;
  } word_t;

  int unsigned m_cnt [2][N];
  bit          m_ovf [2][N];
  word_t       q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    word_t w;
    if (rst) begin
      for (int m = 0; m < 2; m++)
        for (int c = 0; c < N; c++) begin
          m_cnt[m][c] = 0;
          m_ovf[m][c] = 0;
        end
      q.delete();
      return;
    end
    if (q.size() > 0) begin
      if (rd_ready) void'(q.pop_front());
    end else if (snap) begin
      for (int c = 0; c < N; c++) begin
        w.chan = c;
        w.d0   = m_cnt[0][c];
        w.d1   = m_cnt[1][c];
        q.push_back(w);
      end
    end
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < N; c++) begin
        if (clr[c]) begin
          m_cnt[m][c] = 0;
          m_ovf[m][c] = 0;
        end else if (en[c]) begin
          if (m_cnt[m][c] + 1 > MAX) begin
            m_ovf[m][c] = 1;
            m_cnt[m][c] = (m == 1) ? MAX : 0;
          end else begin
            m_cnt[m][c] = m_cnt[m][c] + 1;
          end
        end
      end
  endfunction

  task automatic model_check();
    logic [N-1:0] e0, e1;
    bit           v;
    for (int c = 0; c < N; c++) begin
      e0[c] = m_ovf[0][c];
      e1[c] = m_ovf[1][c];
    end
    v = (q.size() > 0);
    chk("m_ovf_wrap", ovf0, e0);
    chk("m_ovf_sat", ovf1, e1);
    chk("m_busy_wrap", busy0, v);
    chk("m_busy_sat", busy1, v);
    chk("m_valid_wrap", valid0, v);
    chk("m_valid_sat", valid1, v);
    chk("m_chan_wrap", chan0, v ? q[0].chan : 0);
    chk("m_chan_sat", chan1, v ? q[0].chan : 0);
    if (v) begin
      chk("m_data_wrap", data0, q[0].d0);
      chk("m_data_sat", data1, q[0].d1);
    end
  endtask

  task automatic cycle(input logic [N-1:0] e, input logic [N-1:0] c, input logic s,
                       input logic r, input logic rdy);
    en = e; clr = c; snap = s; rst = r; rd_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  typedef struct {
    int unsigned  reps;
    logic [N-1:0] en;
    logic [N-1:0] clr;
    logic         snap;
    logic         rst;
    logic         ready;
    logic [N-1:0] ovf;
    logic         busy;
    int unsigned  chan;
    logic         chkd;
    int unsigned  d0;
    int unsigned  d1;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // reps, en, clr, snap, rst, ready | ovf, busy/valid, chan, check data, data wrap, data sat
    tbl[0]  = '{2,   4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 0, 1'b1, 0, 0};
    tbl[1]  = '{10,  4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 0, 1'b0, 0, 0};
    tbl[2]  = '{1,   4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 0, 1'b1, 10, 10};
    tbl[3]  = '{1,   4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1, 1'b1, 0, 0};
    tbl[4]  = '{1,   4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 2, 1'b1, 10, 10};
    tbl[5]  = '{1,   4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 3, 1'b1, 0, 0};
    tbl[6]  = '{1,   4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 0, 1'b0, 0, 0};
    tbl[7]  = '{1,   4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 0, 1'b1, 0, 0};
    tbl[8]  = '{255, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 0, 1'b0, 0, 0};
    tbl[9]  = '{1,   4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 0, 1'b0, 0, 0};
    tbl[10] = '{1,   4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 0, 1'b1, 0, 255};
    tbl[11] = '{1,   4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1, 1'b1, 0, 0};
    tbl[12] = '{3,   4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 0, 1'b0, 0, 0};

    for (int i = 0; i < 13; i++) begin
      for (int r = 0; r < int'(tbl[i].reps); r++)
        cycle(tbl[i].en, tbl[i].clr, tbl[i].snap, tbl[i].rst, tbl[i].ready);
      chk($sformatf("t%0d_ovf_wrap", i), ovf0, tbl[i].ovf);
      chk($sformatf("t%0d_ovf_sat", i), ovf1, tbl[i].ovf);
      chk($sformatf("t%0d_busy", i), busy0, tbl[i].busy);
      chk($sformatf("t%0d_valid", i), valid1, tbl[i].busy);
      chk($sformatf("t%0d_chan", i), chan0, tbl[i].chan);
      if (tbl[i].chkd) begin
        chk($sformatf("t%0d_data_wrap", i), data0, tbl[i].d0);
        chk($sformatf("t%0d_data_sat", i), data1, tbl[i].d1);
      end
    end

    // Counts 3,7,11,15 then an unstalled readout.
    begin
      logic [N-1:0] e;
      int unsigned  tgt [N];
      tgt = '{3, 7, 11, 15};
      cycle('0, '0, 1'b0, 1'b1, 1'b0);
      for (int t = 0; t < 15; t++) begin
        for (int c = 0; c < N; c++) e[c] = (t < int'(tgt[c]));
        cycle(e, '0, 1'b0, 1'b0, 1'b0);
      end
      cycle('0, '0, 1'b1, 1'b0, 1'b1);
      for (int w = 0; w < N; w++) begin
        chk("seq_valid", valid0, 1'b1);
        chk("seq_chan", chan0, w);
        chk("seq_data", data0, tgt[w]);
        cycle('0, '0, 1'b0, 1'b0, 1'b1);
      end
      chk("seq_busy_end", busy0, 1'b0);
    end

    // Stalled readout with a second snap arriving mid-stream.
    cycle('0, '0, 1'b1, 1'b0, 1'b0);
    cycle('1, '0, 1'b0, 1'b0, 1'b1);
    cycle('1, '0, 1'b1, 1'b0, 1'b0);
    cycle('1, '0, 1'b0, 1'b0, 1'b0);
    chk("stall_chan", chan0, 1);
    chk("stall_data", data0, 7);
    for (int k = 0; k < 3; k++) cycle('0, '0, 1'b0, 1'b0, 1'b1);
    chk("stall_done", busy0, 1'b0);

    // Snapshot coincident with clr[2] while channel 2 holds 9.
    cycle('0, '0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) cycle(4'b0100, '0, 1'b0, 1'b0, 1'b0);
    cycle(4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0);
    cycle(4'b0100, '0, 1'b0, 1'b0, 1'b1);
    cycle(4'b0100, '0, 1'b0, 1'b0, 1'b1);
    chk("clrsnap_chan", chan0, 2);
    chk("clrsnap_data", data0, 9);
    cycle(4'b0100, '0, 1'b0, 1'b0, 1'b0);
    chk("clrsnap_hold", data1, 9);
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b0, 1'b1);

    // Reset after word 1 has been accepted aborts the readout.
    for (int k = 0; k < 5; k++) cycle('1, '0, 1'b0, 1'b0, 1'b0);
    cycle('0, '0, 1'b1, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b1, 1'b1);
    chk("abort_valid", valid0, 1'b0);
    chk("abort_busy", busy1, 1'b0);
    for (int k = 0; k < 3; k++) cycle('0, '0, 1'b0, 1'b0, 1'b1);

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] e, c;
      for (int j = 0; j < N; j++) begin
        e[j] = ($urandom_range(3, 0) != 0);
        c[j] = ($urandom_range(127, 0) == 0);
      end
      cycle(e, c, $urandom_range(7, 0) == 0, $urandom_range(499, 0) == 0,
            $urandom_range(1, 0) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
